// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
// Elastic pipeline stage register carrying one packed DATA_W payload with a
// valid/ready handshake. It supports a synchronous flush for squashing held
// entries. SKID=1 builds a two-entry skid buffer whose in_ready comes from a
// register. SKID=0 builds a single register with combinational in_ready.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (discards everything)
//   flush      in   synchronous squash of all held entries
//   in_valid   in   upstream offers in_data
//   in_ready   out  stage accepts in_data this cycle
//   in_data    in   upstream payload [DATA_W]
//   out_valid  out  out_data holds a valid payload
//   out_ready  in   downstream accepts out_data this cycle
//   out_data   out  payload presented downstream [DATA_W]
//   occupancy  out  number of held entries (0..2, max 1 when SKID=0)
// -----------------------------------------------------------------------------
module pipe_stage_elastic #(
   parameter int unsigned         DATA_W  = 32,
   parameter logic [DATA_W-1:0]   RST_VAL = {DATA_W{1'b0}},
   parameter bit                  SKID    = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   // The state encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   main_data_q, main_data_d;
   logic [DATA_W-1:0]   skid_data_q;
   logic                in_fire;

   // Upstream ready. In skid mode it depends only on state (a flop), so it
   // never combines with out_ready. Reset forces it low.
   always_comb begin
      in_ready = 1'b0;
      if (reset) begin
         in_ready = 1'b0;
      end else if (SKID) begin
         in_ready = (state_q != ST_FULL);
      end else begin
         in_ready = (state_q == ST_EMPTY) | out_ready;
      end
      in_fire = in_valid & in_ready;
   end

   // Next-state and main-register data. Flush drops both held and incoming payloads.
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      if (flush) begin
         state_d     = ST_EMPTY;
         main_data_d = RST_VAL;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d     = ST_ONE;
                  main_data_d = in_data;
               end else begin
                  state_d     = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (in_fire && out_ready) begin
                  // A new payload replaces the one leaving this cycle.
                  state_d     = ST_ONE;
                  main_data_d = in_data;
               end else if (in_fire && SKID) begin
                  // Downstream is stalled, so the new payload parks in skid.
                  state_d     = ST_FULL;
               end else if (out_ready) begin
                  state_d     = ST_EMPTY;
               end else begin
                  state_d     = ST_ONE;
               end
            end
            ST_FULL: begin
               if (out_ready) begin
                  state_d     = ST_ONE;
                  main_data_d = skid_data_q;
               end else begin
                  state_d     = ST_FULL;
               end
            end
            default: begin
               state_d     = ST_EMPTY;
               main_data_d = RST_VAL;
            end
         endcase
      end
   end

   // State and main-register update. Reset has the highest priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         main_data_q <= RST_VAL;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
      end
   end

   generate
      if (SKID) begin : g_skid
         logic [DATA_W-1:0] skid_data_d;

         // Skid loads only when a payload is accepted while main is stalled.
         always_comb begin
            skid_data_d = skid_data_q;
            if (flush) begin
               skid_data_d = RST_VAL;
            end else if ((state_q == ST_ONE) && in_fire && !out_ready) begin
               skid_data_d = in_data;
            end else begin
               skid_data_d = skid_data_q;
            end
         end

         // Skid data register.
         always_ff @(posedge clk) begin
            if (reset) begin
               skid_data_q <= RST_VAL;
            end else begin
               skid_data_q <= skid_data_d;
            end
         end
      end else begin : g_noskid
         assign skid_data_q = RST_VAL;
      end
   endgenerate

   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_data_q;
   assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_elastic
// Drives a SKID=1 and a SKID=0 instance with the same stimulus. Each instance
// is checked every cycle against a small FIFO model that holds up to 2 entries
// (skid mode) or 1 entry (plain mode).
// -----------------------------------------------------------------------------
module tb_pipe_stage_elastic;

   localparam logic [31:0] RST_V = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [31:0] in_data;
   logic        in_ready_s  [2];
   logic        out_valid_s [2];
   logic [31:0] out_data_s  [2];
   logic [1:0]  occ_s       [2];

   int          n_vec = 0;
   int          n_err = 0;

   // Model state per instance: index 0 = skid, 1 = plain.
   logic [31:0] mem [2][2];
   int          cnt  [2];
   logic [31:0] last [2];

   always #5 clk = ~clk;

   pipe_stage_elastic #(.DATA_W(32), .RST_VAL(RST_V), .SKID(1'b1)) u_skid (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_s[0]), .in_data(in_data),
      .out_valid(out_valid_s[0]), .out_ready(out_ready), .out_data(out_data_s[0]),
      .occupancy(occ_s[0]));

   pipe_stage_elastic #(.DATA_W(32), .RST_VAL(RST_V), .SKID(1'b0)) u_plain (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_s[1]), .in_data(in_data),
      .out_valid(out_valid_s[1]), .out_ready(out_ready), .out_data(out_data_s[1]),
      .occupancy(occ_s[1]));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle. Inputs are already applied. The bench checks outputs
   // before the edge and advances the model after it.
   task automatic cycle();
      logic exp_ir [2];
      logic in_f [2];
      logic out_f [2];
      #1;
      for (int i = 0; i < 2; i++) begin
         if (reset)       exp_ir[i] = 1'b0;
         else if (i == 0) exp_ir[i] = (cnt[i] < 2);
         else             exp_ir[i] = (cnt[i] == 0) || out_ready;
         in_f[i]  = in_valid && exp_ir[i];
         out_f[i] = (cnt[i] > 0) && out_ready;
         check_val($sformatf("in_ready[%0d]", i),  {31'd0, in_ready_s[i]},  {31'd0, exp_ir[i]});
         check_val($sformatf("out_valid[%0d]", i), {31'd0, out_valid_s[i]}, {31'd0, cnt[i] > 0});
         check_val($sformatf("occupancy[%0d]", i), {30'd0, occ_s[i]},       cnt[i]);
         check_val($sformatf("out_data[%0d]", i),  out_data_s[i],           last[i]);
      end
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (reset || flush) begin
            cnt[i]  = 0;
            last[i] = RST_V;
         end else begin
            if (out_f[i]) begin
               mem[i][0] = mem[i][1];
               cnt[i]--;
            end
            if (in_f[i]) begin
               mem[i][cnt[i]] = in_data;
               cnt[i]++;
            end
            if (cnt[i] > 0) last[i] = mem[i][0];
         end
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic r, input logic f, input logic iv,
                        input logic [31:0] d, input logic ordy);
      reset = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
      cycle();
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         cnt[i] = 0; last[i] = RST_V; mem[i][0] = 32'd0; mem[i][1] = 32'd0;
      end
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
      @(negedge clk);
      // Reset: in_ready is held low and the registers reach their reset values.
      for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b1, 32'h1111_0000 + k, 1'b1);

      // Streaming 1,2,3,...
      for (int k = 1; k <= 10; k++) drive(1'b0, 1'b0, 1'b1, k, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

      // Backpressure: A accepted, then B arrives while downstream is stalled.
      drive(1'b0, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0);
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b1, 32'hBBBB_0002, 1'b0);
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

      // Flush while FULL with in_valid=1.
      drive(1'b0, 1'b0, 1'b1, 32'hCCCC_0001, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 32'hCCCC_0002, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

      // Reset mid-stream with occupancy 2, then stream 0x5.
      drive(1'b0, 1'b0, 1'b1, 32'hEEEE_0001, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 32'hEEEE_0002, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 32'hEEEE_0003, 1'b1);
      drive(1'b1, 1'b0, 1'b1, 32'hEEEE_0004, 1'b1);
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b1, 32'h5 + k, 1'b1);

      // out_ready toggling 1,0,1,0 under continuous in_valid.
      for (int k = 0; k < 8; k++) drive(1'b0, 1'b0, 1'b1, 32'h7000_0000 + k, ~k[0]);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

      // Random valid/ready, with rare flush and reset.
      for (int k = 0; k < 10000; k++) begin
         drive(($urandom_range(255, 0) == 0),
               ($urandom_range(63, 0) == 0),
               ($urandom_range(3, 0) != 0),
               $urandom(),
               ($urandom_range(2, 0) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed-field stage registers (IF/ID ... MEM/WB) used between pipeline stages.
- Carries one packed DATA_W bus with a valid/ready handshake, so stages can stall independently.
- Adds a synchronous flush for branch/JAL squashing and a selectable skid mode that registers in_ready to break long ready paths.
- One instance per stage boundary; callers pack their control and data fields into in_data.

Parameters:
- DATA_W, 32: width of the packed stage payload.
- RST_VAL, {DATA_W{1'b0}}: value loaded into the data registers on reset and flush. MEM/WB instances use 32'h0040_0000 in the PC field.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  this stage accepts the payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a valid payload.
- out_ready  in  1  downstream accepts the payload this cycle.
- out_data  out  DATA_W  payload presented downstream.
- occupancy  out  2  number of entries held: 0, 1, or 2 (2 only when SKID=1).

Behaviour:
- Transfers:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - All state updates happen on the rising edge of clk.
- Storage:
  - main register: main_valid, main_data.
  - skid register: skid_valid, skid_data. Present only when SKID=1.
  - out_valid = main_valid; out_data = main_data.
- Reset (highest priority):
  - main_valid = skid_valid = 0.
  - main_data = skid_data = RST_VAL.
  - occupancy = 0.
  - in_ready is forced to 0 while reset is high.
  - On the first cycle after reset deasserts, in_ready = 1.
  - Reset mid-transfer discards every held and incoming payload.
- Flush (second priority):
  - Same register effect as reset.
  - in_ready is not forced low; it is 1 in the cycle after flush.
  - An in_fire in the flush cycle completes the handshake, but its payload is dropped.
  - An out_fire in the flush cycle is honoured by downstream, which sees the old out_data.
- SKID=1, in_ready = !skid_valid (registered). States:
  - EMPTY (occ 0):
    - in_fire -> ONE, main <= in_data.
  - ONE (occ 1):
    - in_fire & out_ready -> ONE, main <= in_data.
    - in_fire & !out_ready -> FULL, skid <= in_data, main held.
    - !in_fire & out_ready -> EMPTY.
    - Otherwise hold.
  - FULL (occ 2):
    - in_ready = 0, so in_valid is ignored.
    - out_ready -> ONE, main <= skid_data, skid_valid <= 0.
    - Otherwise hold both entries.
- SKID=0, in_ready = !main_valid | out_ready (combinational). States:
  - EMPTY:
    - in_fire -> ONE.
  - ONE:
    - in_fire -> ONE with new data. This is a simultaneous in_fire and out_fire.
    - out_fire without in_fire -> EMPTY.
    - Otherwise hold.
  - skid registers are not instantiated; occupancy never exceeds 1.
- Latency and throughput:
  - One cycle from in_fire to out_valid in both modes.
  - Full throughput (one transfer per cycle) when out_ready is held at 1.
- Ordering:
  - Payloads leave in acceptance order.
  - No payload is lost except by reset or flush.
  - No payload is duplicated.
- Stall stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change, except via reset or flush.
- Width rule: in_data is captured and presented bit-exact; the block does no arithmetic on the payload.

Test Plan:
- Streaming: SKID=1, DATA_W=32, RST_VAL=32'h0040_0000; after reset, drive in_valid=1 with data 1,2,3,... and out_ready=1 -> out_data is 1,2,3,... starting one cycle after each accept; occupancy stays 1; in_ready stays 1.
- Backpressure: SKID=1; accept A=0xAAAA0001, then drop out_ready for 3 cycles while offering B=0xBBBB0002 -> B goes to skid; occupancy=2; in_ready=0; out_data stays A. Then raise out_ready -> A, then B delivered in order; occupancy goes 2, 1, 0 with no further input.
- Flush while FULL, with in_valid=1 -> next cycle: out_valid=0, occupancy=0, out_data=0x0040_0000, in_ready=1; the flushed-cycle input never appears.
- Reset mid-stream: reset asserted with occupancy=2 -> one cycle later all outputs are at reset values and in_ready=0 while reset is held; after release, data 0x5 streams normally.
- SKID=0 with out_ready toggling 1,0,1,0 under continuous in_valid -> in_ready mirrors out_ready whenever main is valid; no payload is lost or duplicated; occupancy ≤ 1.
- Random valid/ready, both SKID values, 10k cycles -> scoreboard shows in-order, lossless delivery, and out_data stable under stall.
